// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Single-port memory bus controller placed directly below the per-CPU
// icache/dcache block. It serialises an instruction-fill channel and a data
// channel onto one RAM port and returns per-channel wait/load to the caches.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          instruction read request and word address
//   iwait, iload         instruction wait (low for the single completion
//                        cycle) and read data
//   dREN, dWEN, daddr,   data read / write request, word address and
//   dstore               write data
//   dwait, dload         data wait (low for the single completion cycle)
//                        and read data
//   ramREN, ramWEN,      RAM read / write strobes, address and write data
//   ramaddr, ramstore
//   ramload, ramstate    RAM read data and status (0 FREE, 1 BUSY,
//                        2 ACCESS, 3 ERROR)
//   bus_err              sticky: a transfer exhausted its RAM retries
//   dbg_state            current arbiter state (0 IDLE, 1 I_XFER, 2 D_XFER)
//
// Handshake: a channel requests by holding its REN/WEN high with address and
// data stable. The grant is registered in IDLE and held for the whole RAM
// access; the granted channel's wait goes low for exactly one cycle, the
// cycle the RAM reports ACCESS (or the final tolerated ERROR), and its load
// is valid only in that cycle. Dropping the request mid-transfer abandons it
// without a wait-low pulse. Every transfer is followed by one IDLE cycle.
//
// Build option: define IFETCH_FAIR_EN to let an instruction fetch through
// after STARVE_LIMIT consecutive data transfers completed while iREN was
// pending. Without it data has strict priority.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int RETRY_MAX    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int ERR_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(RETRY_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             i_starved;

  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      err_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs are combinational from the registered grant, so an asynchronous
  // reset of state_q drops the RAM strobes immediately.
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    bus_err_d = bus_err_q;
    iwait     = 1'b1;
    iload     = '0;
    dwait     = 1'b1;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;

    case (state_q)
      IDLE: begin
        if (i_starved) begin
          state_d = I_XFER;
        end else if (dREN || dWEN) begin
          state_d = D_XFER;
        end else if (iREN) begin
          state_d = I_XFER;
        end
      end

      I_XFER: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end else if (ramstate == RS_ERROR) begin
          if (err_cnt_q == ERR_LAST) begin
            iwait     = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end

      D_XFER: begin
        // A simultaneous read and write request is serviced as a write.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          dwait   = 1'b0;
          dload   = dWEN ? '0 : ramload;
          state_d = IDLE;
        end else if (ramstate == RS_ERROR) begin
          if (err_cnt_q == ERR_LAST) begin
            dwait     = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Each transfer gets a fresh retry budget.
    if (state_d == IDLE) begin
      err_cnt_d = '0;
    end
  end

`ifdef IFETCH_FAIR_EN
  localparam logic [2:0] STARVE_CNT = 3'(STARVE_LIMIT);

  logic [2:0] dstreak_q, dstreak_d;
  logic       d_done;

  // Only successful data completions count toward starving the fetch path.
  assign d_done    = (state_q == D_XFER) && (dREN || dWEN) && (ramstate == RS_ACCESS);
  assign i_starved = iREN && (dstreak_q == STARVE_CNT);

  always_comb begin
    dstreak_d = dstreak_q;
    if ((state_q == IDLE) && (state_d == I_XFER)) begin
      dstreak_d = '0;
    end else if (d_done) begin
      if (!iREN) begin
        dstreak_d = '0;
      end else if (dstreak_q != 3'd7) begin
        dstreak_d = dstreak_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dstreak_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end
`else
  assign i_starved = 1'b0;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Single-port memory bus controller sitting directly downstream of the per-CPU icache/dcache block.
- Accepts one instruction-fill channel (iREN/iaddr) and one data channel (dREN/dWEN/daddr/dstore) and serialises them onto one RAM port.
- Returns per-channel wait/load to the caches.
- Grant is registered and held for the whole RAM access; a transfer is never preempted.

Parameters:
- RETRY_MAX, 3: consecutive RAM ERROR responses tolerated per transfer before the transfer is abandoned.
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending; used only with IFETCH_FAIR_EN.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iwait  out  1  low for exactly the cycle iload is valid
- iload  out  32  instruction data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  write data
- dwait  out  1  low for exactly the cycle a data read/write completes
- dload  out  32  data read value
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- bus_err  out  1  sticky; set when a transfer exhausts RETRY_MAX

Behaviour:
- Reset values: state IDLE, all counters 0, bus_err 0. Outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- States: IDLE, I_XFER, D_XFER.
- Transitions from IDLE:
  - (dREN|dWEN) -> D_XFER (data priority).
  - else iREN -> I_XFER.
  - else stay in IDLE.
- IDLE drives no RAM strobes.
- In D_XFER:
  - ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - dREN and dWEN both high: treated as a write.
- In I_XFER: ramREN=1, ramaddr=iaddr, ramstore=0.
- Address and data are taken live from the granted channel; caches hold them stable while wait=1.
- Completion on ramstate==ACCESS, same cycle (combinational):
  - Granted channel's wait=0.
  - For a read, its load=ramload.
  - Next state IDLE.
- The other channel's wait stays 1 and its load stays 0 at all times.
- The mandatory IDLE cycle between transfers lets the cache advance its state before re-request.
- Latency: request seen in IDLE at cycle 0, RAM strobes from cycle 1, earliest wait-low cycle 1. Back-to-back transfers cost at least 2 cycles each.
- FREE/BUSY: hold the state, keep strobes asserted.
- ERROR:
  - err_cnt (2-bit saturating, width ≥ clog2(RETRY_MAX+1)) increments; stay in the state and keep strobes asserted (retry).
  - ERROR seen with err_cnt==RETRY_MAX: bus_err<=1, granted wait=0 for that cycle, load=0, next IDLE.
  - err_cnt clears on every entry to IDLE.
- Request withdrawn mid-transfer (granted channel's REN/WEN both low): abort to IDLE next cycle, no wait-low pulse, strobes drop the same cycle.
- Simultaneous i and d requests in IDLE: data wins; instruction waits with iwait=1.
- bus_err clears only on nRST.
- Reset asserted mid-transfer: immediate return to reset values; the RAM strobe drops asynchronously.

Optional Feature:
- Macro IFETCH_FAIR_EN.
- When defined:
  - 3-bit dstreak counter increments on each D_XFER completion while iREN=1.
  - It clears on any I_XFER grant, or when iREN=0 at a data completion.
  - In IDLE with dstreak==STARVE_LIMIT and iREN=1, I_XFER is granted even if a data request is pending.
- When undefined: strict data priority, no counter logic present.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0x8C010004 -> cycle 1: ramREN=1, ramaddr=0x40, iwait=0, iload=0x8C010004; cycle 2: IDLE, iwait=1.
- Same cycle iREN=1 (0x40) and dWEN=1, daddr=0x3100, dstore=0x5 -> data first: ramWEN=1, ramaddr=0x3100, ramstore=0x5, dwait=0. After the IDLE cycle, instruction fetch of 0x40 completes. iwait stays 1 throughout the data transfer.
- dREN, daddr=0x80, ramstate BUSY for 3 cycles then ACCESS with ramload=0xDEADBEEF -> dwait=1 for 3 cycles, then dwait=0 with dload=0xDEADBEEF; the RAM address is stable throughout.
- dREN with ramstate held at ERROR -> 4th ERROR cycle: bus_err=1, dwait=0, dload=0. bus_err remains 1 through subsequent good transfers until nRST.
- iREN in I_XFER with ramstate BUSY, then iREN drops -> next cycle IDLE, ramREN=0, no iwait-low pulse. Separately, nRST pulsed mid D_XFER -> all outputs return to reset values immediately.
- IFETCH_FAIR_EN, STARVE_LIMIT=4: iREN held, 6 back-to-back dREN transfers all with ACCESS -> grant order D,D,D,D,I,D.
